// File: rtl/data_mem.sv
// data_mem: word-addressed data memory with a byte-lane write port, a fixed
// number of wait states per access, a one-request-at-a-time valid/ready
// handshake, and a post-reset sequence that clears every word to zero.
module data_mem #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 32,
   parameter int WAIT     = 1,
   parameter int TEST_IDX = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy,
   output logic [15:0]         test_value
);

   localparam int NB  = DATA_W / 8;
   localparam int OFF = $clog2(NB);
   localparam int IW  = $clog2(DEPTH);

   // Bad parameter sets stop elaboration instead of building a broken memory.
   if (TEST_IDX < 0 || TEST_IDX >= DEPTH) begin : g_bad_test_idx
      $error("data_mem: TEST_IDX must be below DEPTH");
   end
   if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
      $error("data_mem: WAIT must be 0..15");
   end
   if (DATA_W < 16 || (DATA_W % 8) != 0 || DEPTH < 2) begin : g_bad_geom
      $error("data_mem: DATA_W must be a multiple of 8 >= 16, DEPTH >= 2");
   end

   typedef enum logic [1:0] {S_CLR, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state;
   logic [IW-1:0]     clr_idx;
   logic [3:0]        wcnt;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0]    widx;
   logic [ADDR_W+31:0]   widx_ext;
   logic [IW-1:0]        idx;
   logic                 err;
   logic                 acc;

   // Decode the byte address into a word index and classify it as legal or not;
   // the range check is done on a widened copy so any ADDR_W/DEPTH mix compares safely.
   always_comb begin
      widx     = req_addr >> OFF;
      widx_ext = {32'b0, widx};
      idx      = widx[IW-1:0];
      err      = (|req_addr[OFF-1:0]) || (widx_ext >= (ADDR_W+32)'(DEPTH));
      acc      = (state == S_IDLE) && req_valid;
   end

   // Control FSM: clear sweep, accept, count wait states, hold the response.
   // Read data is sampled on the acceptance edge so it reflects the word as it
   // stood then, regardless of how long the response is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_CLR;
         clr_idx <= '0;
         wcnt    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_CLR: begin
               if (clr_idx == IW'(DEPTH - 1)) state <= S_IDLE;
               else                           clr_idx <= clr_idx + 1'b1;
            end
            S_IDLE: begin
               if (req_valid) begin
                  err_q   <= err;
                  rdata_q <= (!err && !req_we) ? mem[idx] : '0;
                  if (WAIT == 0) begin
                     state <= S_RESP;
                  end else begin
                     wcnt  <= 4'(WAIT - 1);
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wcnt == 4'd0) state <= S_RESP;
               else              wcnt  <= wcnt - 1'b1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state   <= S_IDLE;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: state <= S_CLR;
         endcase
      end
   end

   // Storage: zeroed one word per cycle during the clear sweep, otherwise
   // written lane by lane on the edge a legal write is accepted.
   always_ff @(posedge clk) begin
      if (state == S_CLR) begin
         mem[clr_idx] <= '0;
      end else if (acc && req_we && !err) begin
         for (int k = 0; k < NB; k++) begin
            if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
         end
      end
   end

   // Status and response outputs follow the state register; data is masked
   // to zero whenever no response is being presented.
   always_comb begin
      req_ready  = (state == S_IDLE);
      busy       = (state == S_CLR);
      rsp_valid  = (state == S_RESP);
      rsp_rdata  = rsp_valid ? rdata_q : '0;
      rsp_err    = rsp_valid ? err_q : 1'b0;
      test_value = busy ? 16'h0 : mem[TEST_IDX][15:0];
   end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed plus randomized checks of data_mem against a plain
// array model of the memory contents and the documented response timing.
module tb_data_mem;

   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 32;
   localparam int WT    = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [3:0]    req_be;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, busy;
   logic [DW-1:0] rsp_rdata;
   logic [15:0]   test_value;

   always #5 clk = ~clk;

   data_mem #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT(WT), .TEST_IDX(0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .test_value(test_value)
   );

   logic [31:0] model [DEPTH];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // Counts busy cycles after reset release; must be exactly DEPTH.
   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".clr_cycles"}, 32'(n), 32'(DEPTH));
      chk({tag, ".rdy_after_clr"}, {31'b0, req_ready}, 32'd1);
   endtask

   // One full request/response; expectations come from the array model.
   task automatic xact(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
      logic [31:0] exp_rd, rd0;
      logic        exp_err, e0;
      int          n;
      exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
      exp_rd  = '0;
      n = 0;
      while (!req_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".rdy"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
      if (!exp_err) begin
         if (we) begin
            for (int k = 0; k < 4; k++)
               if (be[k]) model[addr >> 2][8*k +: 8] = wd[8*k +: 8];
         end else begin
            exp_rd = model[addr >> 2];
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, ".tv"}, {16'b0, test_value}, {16'b0, model[0][15:0]});
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".lat"}, 32'(n), 32'(WT + 1));
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      rd0 = rsp_rdata; e0 = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, ".hold_vld"}, {31'b0, rsp_valid}, 32'd1);
         chk({tag, ".hold_rdy"}, {31'b0, req_ready}, 32'd0);
         chk({tag, ".hold_rd"}, rsp_rdata, rd0);
         chk({tag, ".hold_err"}, {31'b0, rsp_err}, {31'b0, e0});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, ".done_vld"}, {31'b0, rsp_valid}, 32'd0);
      chk({tag, ".done_rdy"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr, wd;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      model_clear();
      #12;
      chk("rst.busy", {31'b0, busy}, 32'd1);
      chk("rst.ready", {31'b0, req_ready}, 32'd0);
      chk("rst.vld", {31'b0, rsp_valid}, 32'd0);
      chk("rst.err", {31'b0, rsp_err}, 32'd0);
      chk("rst.rdata", rsp_rdata, 32'd0);
      chk("rst.tv", {16'b0, test_value}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      wait_clear("boot");

      xact("rd3fc", 1'b0, 4'h0, 32'h3FC, 32'h0, 0);
      xact("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
      xact("rd10", 1'b0, 4'h0, 32'h10, 32'h0, 0);
      chk("tv_untouched", {16'b0, test_value}, 32'd0);
      xact("pwr10", 1'b1, 4'b0101, 32'h10, 32'h11223344, 0);
      chk("model_partial", model[4], 32'hDE22BE44);
      xact("rd10b", 1'b0, 4'h0, 32'h10, 32'h0, 0);
      xact("rd13", 1'b0, 4'h0, 32'h13, 32'h0, 0);
      xact("rd400", 1'b0, 4'h0, 32'h400, 32'h0, 0);
      xact("wr400", 1'b1, 4'hF, 32'h400, 32'h55AA55AA, 0);
      xact("wrbe0", 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 0);
      xact("rd10c", 1'b0, 4'h0, 32'h10, 32'h0, 5);

      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom_range(0, 1));
         be   = 4'($urandom);
         addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 32'h7FF))
                                            : 32'($urandom_range(0, 255)) << 2;
         wd   = $urandom;
         xact("rnd", we, be, addr, wd, $urandom_range(0, 2));
      end

      xact("wr0", 1'b1, 4'hF, 32'h0, 32'hABCD1234, 0);
      chk("tv_1234", {16'b0, test_value}, 32'h1234);

      // Reset lands while a write sits in its wait state.
      while (!req_ready) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h4; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid.busy", {31'b0, busy}, 32'd1);
      chk("mid.tv", {16'b0, test_value}, 32'd0);
      chk("mid.vld", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      model_clear();
      wait_clear("mid");
      xact("rd0_post", 1'b0, 4'h0, 32'h0, 32'h0, 0);
      xact("rd4_post", 1'b0, 4'h0, 32'h4, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
